// File: rtl/branchctrl.sv
// Branch resolution controller for the r200 integer pipeline.
// It accepts one conditional branch at a time and resolves it in a single
// EVAL cycle. A taken, aligned branch raises a fetch redirect that is held
// until fetch acknowledges it, followed by a one-cycle flush. A taken
// branch whose target has bit 1 set raises a misalign pulse instead.
// Every output is either a register or a decode of the state register, so
// no input reaches an output combinationally.
module branchctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_rs1,
    input  logic [31:0] in_rs2,
    input  logic        kill,
    output logic [4:0]  bt_instrn11_7,
    output logic [6:0]  bt_instrn31_25,
    output logic [31:0] bt_pc,
    input  logic [31:0] bt_br,
    output logic        redir_valid,
    input  logic        redir_ack,
    output logic [31:0] redir_pc,
    output logic        flush,
    output logic        done,
    output logic        misalign,
    output logic [31:0] exc_pc,
    output logic [15:0] taken_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EVAL  = 2'd1,
        REDIR = 2'd2,
        FLUSH = 2'd3
    } state_t;

    state_t      state_reg;
    state_t      state_next;

    // Latched branch fields. Only the instruction bits that matter here are
    // kept: the B-immediate pieces for the target generator and funct3.
    logic [31:0] pc_reg;
    logic [6:0]  instr_hi_reg;
    logic [4:0]  instr_lo_reg;
    logic [2:0]  funct3_reg;
    logic [31:0] rs1_reg;
    logic [31:0] rs2_reg;

    logic [31:0] redir_pc_reg;
    logic [31:0] exc_pc_reg;
    logic [15:0] taken_cnt_reg;
    logic        done_reg;
    logic        misalign_reg;

    logic        done_next;
    logic        misalign_next;
    logic        cnt_inc;
    logic        accept;
    logic        cond_taken;

    // Register-number and opcode fields are not needed for resolution.
    logic        unused_instr_bits;
    assign unused_instr_bits = ^{in_instr[24:15], in_instr[6:0]};

    assign accept = (state_reg == IDLE) && in_valid;

    // Branch condition on the latched operands; funct3 010/011 never branch.
    always_comb begin
        cond_taken = 1'b0;
        case (funct3_reg)
            3'b000:  cond_taken = (rs1_reg == rs2_reg);
            3'b001:  cond_taken = (rs1_reg != rs2_reg);
            3'b100:  cond_taken = ($signed(rs1_reg) <  $signed(rs2_reg));
            3'b101:  cond_taken = ($signed(rs1_reg) >= $signed(rs2_reg));
            3'b110:  cond_taken = (rs1_reg <  rs2_reg);
            3'b111:  cond_taken = (rs1_reg >= rs2_reg);
            default: cond_taken = 1'b0;
        endcase
    end

    // Next-state decode and the one-cycle pulse requests; kill wins over
    // every other event while a branch is in EVAL or REDIR.
    always_comb begin
        state_next    = state_reg;
        done_next     = 1'b0;
        misalign_next = 1'b0;
        cnt_inc       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    state_next = EVAL;
                end
            end
            EVAL: begin
                if (kill) begin
                    state_next = IDLE;
                end else if (!cond_taken) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end else if (bt_br[1]) begin
                    state_next    = IDLE;
                    misalign_next = 1'b1;
                end else begin
                    state_next = REDIR;
                    cnt_inc    = 1'b1;
                end
            end
            REDIR: begin
                if (kill) begin
                    state_next = IDLE;
                end else if (redir_ack) begin
                    state_next = FLUSH;
                end
            end
            FLUSH: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Capture the branch operands on accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_reg       <= 32'd0;
            instr_hi_reg <= 7'd0;
            instr_lo_reg <= 5'd0;
            funct3_reg   <= 3'd0;
            rs1_reg      <= 32'd0;
            rs2_reg      <= 32'd0;
        end else if (accept) begin
            pc_reg       <= in_pc;
            instr_hi_reg <= in_instr[31:25];
            instr_lo_reg <= in_instr[11:7];
            funct3_reg   <= in_instr[14:12];
            rs1_reg      <= in_rs1;
            rs2_reg      <= in_rs2;
        end
    end

    // Target capture in EVAL, exception PC on misalign, and result pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            redir_pc_reg <= 32'd0;
            exc_pc_reg   <= 32'd0;
            done_reg     <= 1'b0;
            misalign_reg <= 1'b0;
        end else begin
            done_reg     <= done_next;
            misalign_reg <= misalign_next;
            if (state_reg == EVAL) begin
                redir_pc_reg <= bt_br;
            end
            if (misalign_next) begin
                exc_pc_reg <= pc_reg;
            end
        end
    end

    // Saturating count of branches that went on to redirect.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            taken_cnt_reg <= 16'd0;
        end else if (cnt_inc && (taken_cnt_reg != 16'hFFFF)) begin
            taken_cnt_reg <= taken_cnt_reg + 16'd1;
        end
    end

    assign in_ready       = (state_reg == IDLE);
    assign redir_valid    = (state_reg == REDIR);
    assign flush          = (state_reg == FLUSH);
    assign done           = done_reg;
    assign misalign       = misalign_reg;
    assign redir_pc       = redir_pc_reg;
    assign exc_pc         = exc_pc_reg;
    assign taken_cnt      = taken_cnt_reg;
    assign bt_pc          = pc_reg;
    assign bt_instrn31_25 = instr_hi_reg;
    assign bt_instrn11_7  = instr_lo_reg;

endmodule

// File: tb/tb_branchctrl.sv
// Self-checking bench for branchctrl: a table of single-branch vectors plus
// hand-written sequences for back-to-back accept, kill, stall, reset and
// counter saturation. The external target generator is modelled here.
module tb_branchctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_instr;
    logic [31:0] in_rs1;
    logic [31:0] in_rs2;
    logic        kill;
    logic [4:0]  bt_instrn11_7;
    logic [6:0]  bt_instrn31_25;
    logic [31:0] bt_pc;
    logic [31:0] bt_br;
    logic        redir_valid;
    logic        redir_ack;
    logic [31:0] redir_pc;
    logic        flush;
    logic        done;
    logic        misalign;
    logic [31:0] exc_pc;
    logic [15:0] taken_cnt;

    always #5 clk = ~clk;

    branchctrl dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_pc          (in_pc),
        .in_instr       (in_instr),
        .in_rs1         (in_rs1),
        .in_rs2         (in_rs2),
        .kill           (kill),
        .bt_instrn11_7  (bt_instrn11_7),
        .bt_instrn31_25 (bt_instrn31_25),
        .bt_pc          (bt_pc),
        .bt_br          (bt_br),
        .redir_valid    (redir_valid),
        .redir_ack      (redir_ack),
        .redir_pc       (redir_pc),
        .flush          (flush),
        .done           (done),
        .misalign       (misalign),
        .exc_pc         (exc_pc),
        .taken_cnt      (taken_cnt)
    );

    // Target generator: pc + sign-extended B-immediate.
    assign bt_br = bt_pc + {{20{bt_instrn31_25[6]}}, bt_instrn11_7[0],
                            bt_instrn31_25[5:0], bt_instrn11_7[4:1], 1'b0};

    int checks = 0;
    int errors = 0;
    int exp_cnt = 0;

    // kind: 0 not taken, 1 taken and aligned, 2 taken misaligned
    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [1:0]  kind;
        logic [31:0] target;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sat_inc(input int c);
        return (c >= 65535) ? 65535 : c + 1;
    endfunction

    // Apply one branch starting at a negedge with the DUT idle; ack a
    // redirect immediately and return at a negedge with the DUT idle again.
    task automatic run_vec(input vec_t v, input int idx);
        int e0;
        e0 = errors;
        in_pc    = v.pc;
        in_instr = v.instr;
        in_rs1   = v.rs1;
        in_rs2   = v.rs2;
        in_valid = 1'b1;
        chk("ready_idle", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("ready_eval", {31'd0, in_ready}, 32'd0);
        chk("done_eval", {31'd0, done}, 32'd0);
        chk("redir_eval", {31'd0, redir_valid}, 32'd0);
        @(negedge clk);
        chk("done", {31'd0, done}, {31'd0, v.kind == 2'd0});
        chk("misalign", {31'd0, misalign}, {31'd0, v.kind == 2'd2});
        chk("redir_valid", {31'd0, redir_valid}, {31'd0, v.kind == 2'd1});
        if (v.kind == 2'd1) begin
            exp_cnt = sat_inc(exp_cnt);
            chk("redir_pc", redir_pc, v.target);
            chk("ready_redir", {31'd0, in_ready}, 32'd0);
            redir_ack = 1'b1;
            @(negedge clk);
            redir_ack = 1'b0;
            chk("flush", {31'd0, flush}, 32'd1);
            chk("redir_after_ack", {31'd0, redir_valid}, 32'd0);
            chk("ready_flush", {31'd0, in_ready}, 32'd0);
            @(negedge clk);
            chk("flush_once", {31'd0, flush}, 32'd0);
            chk("ready_back", {31'd0, in_ready}, 32'd1);
        end else begin
            chk("ready_c2", {31'd0, in_ready}, 32'd1);
            if (v.kind == 2'd2) begin
                chk("exc_pc", exc_pc, v.pc);
            end
            @(negedge clk);
            chk("done_pulse", {31'd0, done}, 32'd0);
            chk("misalign_pulse", {31'd0, misalign}, 32'd0);
            chk("no_flush", {31'd0, flush}, 32'd0);
            chk("no_redir", {31'd0, redir_valid}, 32'd0);
        end
        chk("taken_cnt", {16'd0, taken_cnt}, exp_cnt[31:0]);
        $display("vec %0d pc=0x%08h instr=0x%08h kind=%0d cnt=%0d %s",
                 idx, v.pc, v.instr, v.kind, taken_cnt, (errors == e0) ? "ok" : "bad");
    endtask

    initial begin
        // pc, instr, rs1, rs2, kind, target
        vecs[0]  = '{32'h100, 32'h00208463, 32'd5,        32'd5,        2'd1, 32'h108}; // BEQ taken
        vecs[1]  = '{32'h120, 32'h00209463, 32'd7,        32'd7,        2'd0, 32'h0};   // BNE not taken
        vecs[2]  = '{32'h300, 32'h0020C463, 32'hFFFFFFFF, 32'd1,        2'd1, 32'h308}; // BLT taken
        vecs[3]  = '{32'h310, 32'h0020E463, 32'hFFFFFFFF, 32'd1,        2'd0, 32'h0};   // BLTU not taken
        vecs[4]  = '{32'h320, 32'h0020D463, 32'hFFFFFFFF, 32'd1,        2'd0, 32'h0};   // BGE not taken
        vecs[5]  = '{32'h400, 32'h0020F463, 32'hFFFFFFFF, 32'd1,        2'd1, 32'h408}; // BGEU taken
        vecs[6]  = '{32'h200, 32'hFE000EE3, 32'd0,        32'd0,        2'd1, 32'h1FC}; // BEQ -4
        vecs[7]  = '{32'h100, 32'h00000363, 32'd0,        32'd0,        2'd2, 32'h0};   // misaligned +6
        vecs[8]  = '{32'h140, 32'h0020A463, 32'd5,        32'd5,        2'd0, 32'h0};   // funct3 010
        vecs[9]  = '{32'h150, 32'h0020B463, 32'd5,        32'd9,        2'd0, 32'h0};   // funct3 011
        vecs[10] = '{32'h160, 32'h00208463, 32'd1,        32'd2,        2'd0, 32'h0};   // BEQ not taken
        vecs[11] = '{32'h500, 32'h00209463, 32'd1,        32'd2,        2'd1, 32'h508}; // BNE taken
        vecs[12] = '{32'h600, 32'h0020D463, 32'd1,        32'hFFFFFFFF, 2'd1, 32'h608}; // BGE taken
        vecs[13] = '{32'h610, 32'h0020C463, 32'd3,        32'd3,        2'd0, 32'h0};   // BLT equal

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_pc     = 32'd0;
        in_instr  = 32'd0;
        in_rs1    = 32'd0;
        in_rs2    = 32'd0;
        kill      = 1'b0;
        redir_ack = 1'b0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_redir", {31'd0, redir_valid}, 32'd0);
        chk("rst_flush", {31'd0, flush}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_misalign", {31'd0, misalign}, 32'd0);
        chk("rst_redir_pc", redir_pc, 32'd0);
        chk("rst_exc_pc", exc_pc, 32'd0);
        chk("rst_cnt", {16'd0, taken_cnt}, 32'd0);
        chk("rst_bt", {bt_instrn31_25, bt_instrn11_7, 20'd0} | bt_pc, 32'd0);
        $display("reset checked");
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 14; i++) begin
            run_vec(vecs[i], i);
        end

        // Back-to-back: not-taken BNE, second branch held on in_valid
        in_pc = 32'h700; in_instr = 32'h00209463; in_rs1 = 32'd7; in_rs2 = 32'd7;
        in_valid = 1'b1;
        @(negedge clk);
        in_pc = 32'h800; in_instr = 32'h00208463; in_rs1 = 32'd5; in_rs2 = 32'd5;
        chk("b2b_ready_eval", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        chk("b2b_done", {31'd0, done}, 32'd1);
        chk("b2b_ready_c2", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("b2b_accepted", {31'd0, in_ready}, 32'd0);
        chk("b2b_done_once", {31'd0, done}, 32'd0);
        @(negedge clk);
        exp_cnt = sat_inc(exp_cnt);
        chk("b2b_redir", {31'd0, redir_valid}, 32'd1);
        chk("b2b_redir_pc", redir_pc, 32'h808);
        redir_ack = 1'b1;
        @(negedge clk);
        redir_ack = 1'b0;
        chk("b2b_flush", {31'd0, flush}, 32'd1);
        @(negedge clk);
        chk("b2b_cnt", {16'd0, taken_cnt}, exp_cnt[31:0]);
        $display("back-to-back accept checked cnt=%0d", taken_cnt);

        // Kill in EVAL: taken branch discarded, counter untouched
        in_pc = 32'h900; in_instr = 32'h00208463; in_rs1 = 32'd5; in_rs2 = 32'd5;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        chk("keval_redir", {31'd0, redir_valid}, 32'd0);
        chk("keval_done", {31'd0, done}, 32'd0);
        chk("keval_ready", {31'd0, in_ready}, 32'd1);
        chk("keval_cnt", {16'd0, taken_cnt}, exp_cnt[31:0]);
        @(negedge clk);
        chk("keval_flush", {31'd0, flush}, 32'd0);
        $display("kill in EVAL checked");

        // Stall in REDIR for 5 cycles, then kill together with ack
        in_pc = 32'hA00; in_instr = 32'h00208463; in_rs1 = 32'd5; in_rs2 = 32'd5;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        exp_cnt = sat_inc(exp_cnt);
        for (int k = 0; k < 5; k++) begin
            chk("stall_redir", {31'd0, redir_valid}, 32'd1);
            chk("stall_pc", redir_pc, 32'hA08);
            chk("stall_ready", {31'd0, in_ready}, 32'd0);
            @(negedge clk);
        end
        kill = 1'b1;
        redir_ack = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        redir_ack = 1'b0;
        chk("kill_redir", {31'd0, redir_valid}, 32'd0);
        chk("kill_flush", {31'd0, flush}, 32'd0);
        chk("kill_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        chk("kill_flush2", {31'd0, flush}, 32'd0);
        chk("kill_cnt", {16'd0, taken_cnt}, exp_cnt[31:0]);
        $display("stall and kill checked cnt=%0d", taken_cnt);

        // Reset asserted mid-REDIR, away from any clock edge
        in_pc = 32'hB00; in_instr = 32'h00208463; in_rs1 = 32'd5; in_rs2 = 32'd5;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        chk("rr_redir", {31'd0, redir_valid}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        exp_cnt = 0;
        chk("rr_redir_drop", {31'd0, redir_valid}, 32'd0);
        chk("rr_redir_pc", redir_pc, 32'd0);
        chk("rr_exc_pc", exc_pc, 32'd0);
        chk("rr_cnt", {16'd0, taken_cnt}, 32'd0);
        chk("rr_bt_pc", bt_pc, 32'd0);
        chk("rr_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rr_no_flush", {31'd0, flush}, 32'd0);
        chk("rr_idle", {31'd0, redir_valid}, 32'd0);
        $display("reset mid-REDIR checked");

        // Saturation: preset the counter just below the limit
        force dut.taken_cnt_reg = 16'hFFFE;
        @(negedge clk);
        release dut.taken_cnt_reg;
        exp_cnt = 65534;
        @(negedge clk);
        chk("sat_preset", {16'd0, taken_cnt}, 32'h0000FFFE);
        run_vec(vecs[0], 100);
        run_vec(vecs[0], 101);
        chk("sat_hold", {16'd0, taken_cnt}, 32'h0000FFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
